// File: rtl/bp_pkg.sv
// bp_pkg: shared branch-predictor definitions.
// Holds the default feature and history widths. These are the values the
// ai_pred instance and bp_feat_queue must both be built with. The package
// also holds the in-flight entry layout at those default widths.
package bp_pkg;

  localparam int BP_FEAT     = 8;
  localparam int BP_GHR_BITS = 4;
  localparam int BP_DEPTH    = 8;
  localparam int BP_PC_W     = 32;

  // One in-flight branch: features sent to ai_pred, the prediction made, and
  // the speculative GHR as it was before this branch shifted in.
  typedef struct packed {
    logic [BP_FEAT-1:0]     features;
    logic                   pred;
    logic [BP_GHR_BITS-1:0] ghr_ckpt;
  } bp_entry_t;

endpackage

// File: rtl/bp_inflight_fifo.sv
// bp_inflight_fifo: circular buffer of in-flight branch entries.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   push, wdata      write one entry (caller guarantees !full)
//   pop              retire the head entry (caller guarantees !empty)
//   clear            drop every entry: rd_ptr jumps to wr_ptr, count -> 0
//   rdata            head entry, combinational
//   full, empty      status flags
//   count            entries held
module bp_inflight_fifo #(
  parameter int W     = 13,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  input  logic          clear,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_nxt;

  assign rdata = mem[rd_ptr];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == CW'(0));

  // Storage array; entries need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Next occupancy from the push/pop pair; clear wins over both.
  always_comb begin
    count_nxt = count_q;
    if (clear) begin
      count_nxt = CW'(0);
    end else begin
      case ({push, pop})
        2'b10:   count_nxt = count_q + CW'(1);
        2'b01:   count_nxt = count_q - CW'(1);
        default: count_nxt = count_q;
      endcase
    end
  end

  // Pointer and count registers; pointers wrap naturally (DEPTH is 2^AW).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= AW'(0);
      rd_ptr  <= AW'(0);
      count_q <= CW'(0);
    end else begin
      count_q <= count_nxt;
      if (clear) begin
        rd_ptr <= wr_ptr;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

endmodule

// File: rtl/bp_feat_queue.sv
// bp_feat_queue: feature generator and in-flight branch tracker for ai_pred.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   fetch_valid, fetch_pc      branch presented by fetch
//   fetch_ready                queue not full
//   predict_en, features       combinational prediction request to ai_pred
//   pred_taken                 ai_pred prediction, same cycle
//   ex_valid, ex_taken         resolution of the oldest in-flight branch
//   ex_mispredict              combinational: head prediction was wrong
//   flush                      pipeline flush, kills all in-flight entries
//   train_en, train_features,
//   actual_taken               registered training port to ai_pred
//   occupancy                  entries held
//   resolve_cnt, mispred_cnt   saturating event counters
//   underflow_err              sticky: resolve seen with an empty queue
module bp_feat_queue
  import bp_pkg::*;
#(
  parameter int FEAT     = BP_FEAT,
  parameter int GHR_BITS = BP_GHR_BITS,
  parameter int DEPTH    = BP_DEPTH,
  parameter int PC_W     = BP_PC_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fetch_valid,
  input  logic [PC_W-1:0]          fetch_pc,
  output logic                     fetch_ready,
  output logic                     predict_en,
  output logic [FEAT-1:0]          features,
  input  logic                     pred_taken,
  input  logic                     ex_valid,
  input  logic                     ex_taken,
  output logic                     ex_mispredict,
  input  logic                     flush,
  output logic                     train_en,
  output logic [FEAT-1:0]          train_features,
  output logic                     actual_taken,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [31:0]              resolve_cnt,
  output logic [31:0]              mispred_cnt,
  output logic                     underflow_err
);

  // Same layout as bp_entry_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [FEAT-1:0]     features;
    logic                pred;
    logic [GHR_BITS-1:0] ghr_ckpt;
  } entry_t;

  // Shift one outcome into a history register (oldest bit falls off).
  function automatic logic [GHR_BITS-1:0] shift_in(input logic [GHR_BITS-1:0] h,
                                                   input logic b);
    logic [GHR_BITS-1:0] r;
    r    = h << 1;
    r[0] = b;
    return r;
  endfunction

  logic [GHR_BITS-1:0] ghr;
  logic [GHR_BITS-1:0] arch_ghr;
  logic [GHR_BITS-1:0] ghr_nxt;
  logic [GHR_BITS-1:0] arch_ghr_nxt;
  entry_t              wentry;
  entry_t              head;
  logic                full;
  logic                empty;
  logic                resolve;
  logic                push;
  logic                clear;
  logic                unused_pc_bits;

  assign features      = {fetch_pc[FEAT-GHR_BITS+1:2], ghr};
  assign fetch_ready   = !full;
  assign predict_en    = fetch_valid & fetch_ready;
  assign resolve       = ex_valid & !empty;
  assign ex_mispredict = resolve & (ex_taken != head.pred);
  // A mispredict or flush kills the wrong path, including this cycle's fetch.
  assign push          = predict_en & !ex_mispredict & !flush;
  assign clear         = flush | ex_mispredict;
  assign unused_pc_bits = ^{fetch_pc[PC_W-1:FEAT-GHR_BITS+2], fetch_pc[1:0]};

  assign wentry.features = features;
  assign wentry.pred     = pred_taken;
  assign wentry.ghr_ckpt = ghr;

  bp_inflight_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wentry),
    .pop   (resolve),
    .clear (clear),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (occupancy)
  );

  // History repair priority: flush restores the committed history (after this
  // cycle's resolve), a mispredict replays from the head checkpoint, otherwise
  // a accepted fetch shifts its prediction in.
  always_comb begin
    arch_ghr_nxt = arch_ghr;
    ghr_nxt      = ghr;
    if (resolve) begin
      arch_ghr_nxt = shift_in(arch_ghr, ex_taken);
    end else begin
      arch_ghr_nxt = arch_ghr;
    end
    if (flush) begin
      ghr_nxt = arch_ghr_nxt;
    end else if (ex_mispredict) begin
      ghr_nxt = shift_in(head.ghr_ckpt, ex_taken);
    end else if (push) begin
      ghr_nxt = shift_in(ghr, pred_taken);
    end else begin
      ghr_nxt = ghr;
    end
  end

  // History registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr      <= GHR_BITS'(0);
      arch_ghr <= GHR_BITS'(0);
    end else begin
      ghr      <= ghr_nxt;
      arch_ghr <= arch_ghr_nxt;
    end
  end

  // Training port: one-cycle strobe carrying the resolved head's features.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      train_en       <= 1'b0;
      train_features <= FEAT'(0);
      actual_taken   <= 1'b0;
    end else begin
      train_en <= resolve;
      if (resolve) begin
        train_features <= head.features;
        actual_taken   <= ex_taken;
      end
    end
  end

  // Saturating event counters and the sticky underflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resolve_cnt   <= 32'd0;
      mispred_cnt   <= 32'd0;
      underflow_err <= 1'b0;
    end else begin
      if (resolve && (resolve_cnt != 32'hFFFF_FFFF)) begin
        resolve_cnt <= resolve_cnt + 32'd1;
      end
      if (ex_mispredict && (mispred_cnt != 32'hFFFF_FFFF)) begin
        mispred_cnt <= mispred_cnt + 32'd1;
      end
      if (ex_valid && empty) begin
        underflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bp_feat_queue.sv
// Directed self-checking bench for bp_feat_queue (default parameters).
module tb_bp_feat_queue;

  logic        clk;
  logic        rst_n;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        fetch_ready;
  logic        predict_en;
  logic [7:0]  features;
  logic        pred_taken;
  logic        ex_valid;
  logic        ex_taken;
  logic        ex_mispredict;
  logic        flush;
  logic        train_en;
  logic [7:0]  train_features;
  logic        actual_taken;
  logic [3:0]  occupancy;
  logic [31:0] resolve_cnt;
  logic [31:0] mispred_cnt;
  logic        underflow_err;

  int total;
  int bad;

  bp_feat_queue dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_valid    (fetch_valid),
    .fetch_pc       (fetch_pc),
    .fetch_ready    (fetch_ready),
    .predict_en     (predict_en),
    .features       (features),
    .pred_taken     (pred_taken),
    .ex_valid       (ex_valid),
    .ex_taken       (ex_taken),
    .ex_mispredict  (ex_mispredict),
    .flush          (flush),
    .train_en       (train_en),
    .train_features (train_features),
    .actual_taken   (actual_taken),
    .occupancy      (occupancy),
    .resolve_cnt    (resolve_cnt),
    .mispred_cnt    (mispred_cnt),
    .underflow_err  (underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    fetch_valid = 1'b0;
    fetch_pc    = 32'd0;
    pred_taken  = 1'b0;
    ex_valid    = 1'b0;
    ex_taken    = 1'b0;
    flush       = 1'b0;
    rst_n       = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic enq(input logic [31:0] pc, input logic pred);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    pred_taken  = pred;
    step();
    fetch_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
    total++; if (fetch_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", fetch_ready); end
    total++; if (train_en !== 1'b0) begin bad++; $display("FAIL rst_train got=%b exp=0", train_en); end
    total++; if (features !== 8'h00) begin bad++; $display("FAIL rst_feat got=%h exp=00", features); end
    total++; if (resolve_cnt !== 32'd0 || mispred_cnt !== 32'd0 || underflow_err !== 1'b0) begin
      bad++; $display("FAIL rst_cnt got=%0d/%0d/%b exp=0/0/0", resolve_cnt, mispred_cnt, underflow_err);
    end
  endtask

  task automatic test_features();
    do_reset();
    fetch_valid = 1'b1; fetch_pc = 32'h0000_0014; pred_taken = 1'b1;
    #1;
    total++; if (features !== 8'b0101_0000) begin bad++; $display("FAIL feat_first got=%b exp=01010000", features); end
    total++; if (predict_en !== 1'b1) begin bad++; $display("FAIL feat_pen got=%b exp=1", predict_en); end
    step();
    fetch_valid = 1'b0;
    #1;
    total++; if (features !== 8'b0101_0001) begin bad++; $display("FAIL feat_ghr got=%b exp=01010001", features); end
    total++; if (occupancy !== 4'd1) begin bad++; $display("FAIL feat_occ got=%0d exp=1", occupancy); end
    total++; if (predict_en !== 1'b0) begin bad++; $display("FAIL feat_pen_idle got=%b exp=0", predict_en); end
  endtask

  task automatic test_in_order();
    logic [7:0] exp_f [3];
    logic       outc  [3];
    exp_f[0] = 8'h80; exp_f[1] = 8'h91; exp_f[2] = 8'hA2;
    outc[0] = 1'b1; outc[1] = 1'b0; outc[2] = 1'b1;
    do_reset();
    enq(32'h0000_0020, 1'b1);
    enq(32'h0000_0024, 1'b0);
    enq(32'h0000_0028, 1'b1);
    total++; if (occupancy !== 4'd3) begin bad++; $display("FAIL ord_occ3 got=%0d exp=3", occupancy); end
    for (int i = 0; i < 3; i++) begin
      ex_valid = 1'b1; ex_taken = outc[i];
      #1;
      total++; if (ex_mispredict !== 1'b0) begin bad++; $display("FAIL ord_mp%0d got=%b exp=0", i, ex_mispredict); end
      step();
      total++; if (train_en !== 1'b1 || train_features !== exp_f[i] || actual_taken !== outc[i]) begin
        bad++; $display("FAIL ord_train%0d got=%b/%h/%b exp=1/%h/%b", i, train_en, train_features, actual_taken, exp_f[i], outc[i]);
      end
    end
    ex_valid = 1'b0;
    step();
    total++; if (train_en !== 1'b0) begin bad++; $display("FAIL ord_pulse_end got=%b exp=0", train_en); end
    total++; if (occupancy !== 4'd0 || mispred_cnt !== 32'd0 || resolve_cnt !== 32'd3) begin
      bad++; $display("FAIL ord_cnt got=%0d/%0d/%0d exp=0/0/3", occupancy, mispred_cnt, resolve_cnt);
    end
    // A flush copies arch_ghr into the visible history.
    flush = 1'b1;
    step();
    flush = 1'b0; fetch_pc = 32'd0;
    #1;
    total++; if (features !== 8'h05) begin bad++; $display("FAIL ord_arch got=%h exp=05", features); end
  endtask

  task automatic test_mispredict();
    do_reset();
    for (int i = 0; i < 4; i++) enq(32'd0, 1'b1);
    #1;
    total++; if (features !== 8'h0F) begin bad++; $display("FAIL mp_spec got=%h exp=0F", features); end
    ex_valid = 1'b1; ex_taken = 1'b0;
    fetch_valid = 1'b1; fetch_pc = 32'd0; pred_taken = 1'b1;
    #1;
    total++; if (ex_mispredict !== 1'b1) begin bad++; $display("FAIL mp_flag got=%b exp=1", ex_mispredict); end
    step();
    ex_valid = 1'b0; fetch_valid = 1'b0;
    #1;
    total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL mp_occ got=%0d exp=0", occupancy); end
    total++; if (features !== 8'h00) begin bad++; $display("FAIL mp_ghr got=%h exp=00", features); end
    total++; if (mispred_cnt !== 32'd1 || resolve_cnt !== 32'd1) begin
      bad++; $display("FAIL mp_cnt got=%0d/%0d exp=1/1", mispred_cnt, resolve_cnt);
    end
    total++; if (train_en !== 1'b1 || actual_taken !== 1'b0) begin
      bad++; $display("FAIL mp_train got=%b/%b exp=1/0", train_en, actual_taken);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) enq(32'd0, 1'b0);
    fetch_valid = 1'b1; fetch_pc = 32'd0; pred_taken = 1'b0;
    #1;
    total++; if (fetch_ready !== 1'b0 || predict_en !== 1'b0) begin
      bad++; $display("FAIL full_ready got=%b/%b exp=0/0", fetch_ready, predict_en);
    end
    total++; if (occupancy !== 4'd8) begin bad++; $display("FAIL full_occ got=%0d exp=8", occupancy); end
    ex_valid = 1'b1; ex_taken = 1'b0;
    step();
    ex_valid = 1'b0; fetch_valid = 1'b0;
    #1;
    total++; if (occupancy !== 4'd7) begin bad++; $display("FAIL full_pop_occ got=%0d exp=7", occupancy); end
    total++; if (fetch_ready !== 1'b1) begin bad++; $display("FAIL full_ready_after got=%b exp=1", fetch_ready); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) enq(32'd0, 1'b1);
    ex_valid = 1'b1; ex_taken = 1'b1;
    step();
    step();
    // arch_ghr is now 0011, one correct-prediction entry remains.
    flush = 1'b1; fetch_valid = 1'b1; fetch_pc = 32'd0; pred_taken = 1'b0;
    step();
    flush = 1'b0; ex_valid = 1'b0; fetch_valid = 1'b0;
    #1;
    total++; if (train_en !== 1'b1) begin bad++; $display("FAIL fl_train got=%b exp=1", train_en); end
    total++; if (features !== 8'h07) begin bad++; $display("FAIL fl_ghr got=%h exp=07", features); end
    total++; if (occupancy !== 4'd0 || resolve_cnt !== 32'd3 || mispred_cnt !== 32'd0) begin
      bad++; $display("FAIL fl_state got=%0d/%0d/%0d exp=0/3/0", occupancy, resolve_cnt, mispred_cnt);
    end
  endtask

  task automatic test_underflow_and_reset();
    do_reset();
    ex_valid = 1'b1; ex_taken = 1'b1;
    step();
    ex_valid = 1'b0;
    #1;
    total++; if (train_en !== 1'b0) begin bad++; $display("FAIL uf_train got=%b exp=0", train_en); end
    total++; if (underflow_err !== 1'b1) begin bad++; $display("FAIL uf_flag got=%b exp=1", underflow_err); end
    total++; if (resolve_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
      bad++; $display("FAIL uf_cnt got=%0d/%0d exp=0/0", resolve_cnt, mispred_cnt);
    end
    enq(32'h0000_0014, 1'b1);
    enq(32'h0000_0018, 1'b1);
    ex_valid = 1'b1; ex_taken = 1'b1;
    step();
    ex_valid = 1'b0;
    total++; if (underflow_err !== 1'b1 || train_en !== 1'b1) begin
      bad++; $display("FAIL uf_sticky got=%b/%b exp=1/1", underflow_err, train_en);
    end
    // Async reset in mid-cycle clears everything without waiting for a clock.
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (occupancy !== 4'd0 || train_en !== 1'b0 || underflow_err !== 1'b0 || resolve_cnt !== 32'd0) begin
      bad++; $display("FAIL arst got=%0d/%b/%b/%0d exp=0/0/0/0", occupancy, train_en, underflow_err, resolve_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    total++; if (train_en !== 1'b0 || occupancy !== 4'd0) begin
      bad++; $display("FAIL arst_after got=%b/%0d exp=0/0", train_en, occupancy);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_features();
    test_in_order();
    test_mispredict();
    test_full();
    test_flush();
    test_underflow_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
